// File: rtl/line_clear_engine_pkg.sv
// Shared board geometry, row-word layout and FSM state type for the line clear engine.
package line_clear_engine_pkg;

    localparam int unsigned CELL_W      = 2;
    localparam int unsigned BOARD_COLS  = 10;
    localparam int unsigned BOARD_ROWS  = 20;
    localparam int unsigned ROW_W       = 32;
    localparam int unsigned CELL_BITS   = CELL_W * BOARD_COLS;
    localparam int unsigned RAM_ADDR_W  = 11;
    localparam int unsigned ROW_0_ADDR  = 2;
    localparam int unsigned PTR_W       = 5;
    localparam int unsigned CNT_W       = 5;

    localparam logic [CELL_W-1:0] EMPTY_CELL = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        EVAL,
        FILL,
        DONE
    } lce_state_t;

endpackage

// File: rtl/line_clear_engine_row_full_detect.sv
// Flags a board row whose cell field has no empty cell; also usable for game-over checks.
module row_full_detect
    import line_clear_engine_pkg::*;
(
    input  logic [CELL_BITS-1:0] cells,
    output logic                 full_c
);

    always_comb begin
        full_c = 1'b1;
        for (int c = 0; c < int'(BOARD_COLS); c++) begin
            if (cells[c*CELL_W +: CELL_W] == EMPTY_CELL) begin
                full_c = 1'b0;
            end
        end
    end

endmodule

// File: rtl/line_clear_engine.sv
// Compacts the board RAM in place: drops full rows, shifts survivors down, zero-fills the top.
module line_clear_engine
    import line_clear_engine_pkg::*;
#(
    parameter int unsigned NUM_ROWS = BOARD_ROWS,
    parameter int unsigned ROW_BASE = ROW_0_ADDR,
    parameter int unsigned ADDR_W   = RAM_ADDR_W
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    lines_cleared,
    output logic [NUM_ROWS-1:0] cleared_mask,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic                ram_wren,
    output logic [ROW_W-1:0]    ram_wdata,
    input  logic [ROW_W-1:0]    ram_rdata
);

    lce_state_t          state, state_nxt;
    logic [PTR_W-1:0]    rd, rd_nxt;
    logic [PTR_W-1:0]    wr, wr_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [NUM_ROWS-1:0] mask, mask_nxt;
    logic                row_full_c;
    logic [ADDR_W-1:0]   rd_addr_c;
    logic [ADDR_W-1:0]   wr_addr_c;

    row_full_detect u_row_full (
        .cells  (ram_rdata[CELL_BITS-1:0]),
        .full_c (row_full_c)
    );

    assign rd_addr_c = ADDR_W'(ROW_BASE) + ADDR_W'(rd);
    assign wr_addr_c = ADDR_W'(ROW_BASE) + ADDR_W'(wr);

    // State, pointers and the result registers that software reads after done.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= IDLE;
            rd            <= '0;
            wr            <= '0;
            cnt           <= '0;
            mask          <= '0;
            lines_cleared <= '0;
            cleared_mask  <= '0;
        end else begin
            state <= state_nxt;
            rd    <= rd_nxt;
            wr    <= wr_nxt;
            cnt   <= cnt_nxt;
            mask  <= mask_nxt;
            if (state == DONE) begin
                lines_cleared <= cnt;
                cleared_mask  <= mask;
            end
        end
    end

    // RAM port outputs are decoded from the current state so EVAL can forward rdata in-cycle.
    always_comb begin
        state_nxt = state;
        rd_nxt    = rd;
        wr_nxt    = wr;
        cnt_nxt   = cnt;
        mask_nxt  = mask;
        busy      = 1'b0;
        done      = 1'b0;
        ram_addr  = '0;
        ram_wren  = 1'b0;
        ram_wdata = '0;

        case (state)
            IDLE: begin
                if (start) begin
                    rd_nxt    = PTR_W'(NUM_ROWS - 1);
                    wr_nxt    = PTR_W'(NUM_ROWS - 1);
                    cnt_nxt   = '0;
                    mask_nxt  = '0;
                    state_nxt = READ;
                end
            end

            READ: begin
                busy      = 1'b1;
                ram_addr  = rd_addr_c;
                state_nxt = EVAL;
            end

            EVAL: begin
                busy = 1'b1;
                if (row_full_c) begin
                    cnt_nxt      = cnt + CNT_W'(1);
                    mask_nxt[rd] = 1'b1;
                end else begin
                    if (wr != rd) begin
                        ram_addr  = wr_addr_c;
                        ram_wren  = 1'b1;
                        ram_wdata = ram_rdata;
                    end
                    // Holding at zero covers the last row of a run with nothing cleared.
                    if (wr != '0) begin
                        wr_nxt = wr - PTR_W'(1);
                    end
                end
                if (rd == '0) begin
                    state_nxt = (cnt_nxt != '0) ? FILL : DONE;
                end else begin
                    rd_nxt    = rd - PTR_W'(1);
                    state_nxt = READ;
                end
            end

            FILL: begin
                busy      = 1'b1;
                ram_addr  = wr_addr_c;
                ram_wren  = 1'b1;
                ram_wdata = '0;
                if (wr == '0) begin
                    state_nxt = DONE;
                end else begin
                    wr_nxt = wr - PTR_W'(1);
                end
            end

            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end

            default: state_nxt = IDLE;
        endcase

        if (RESET) begin
            busy      = 1'b0;
            done      = 1'b0;
            ram_addr  = '0;
            ram_wren  = 1'b0;
            ram_wdata = '0;
        end
    end

endmodule

// File: tb/tb_line_clear_engine.sv
// Directed bench for line_clear_engine with a behavioural board RAM on port B.
module tb_line_clear_engine;

    localparam int unsigned NR   = 20;
    localparam int unsigned RB   = 2;
    localparam int unsigned NVEC = 8;
    localparam logic [31:0] SENT = 32'hDEADBEEF;

    typedef struct packed {
        logic [NR-1:0][31:0] init;
        logic [NR-1:0][31:0] expd;
        logic [4:0]          lines;
        logic [NR-1:0]       mask;
        logic [7:0]          writes;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        start;
    logic        busy;
    logic        done;
    logic [4:0]  lines_cleared;
    logic [NR-1:0] cleared_mask;
    logic [10:0] ram_addr;
    logic        ram_wren;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    logic [31:0]         mem [32];
    logic                tb_load = 1'b0;
    logic                tb_clr  = 1'b0;
    logic [NR-1:0][31:0] tb_board;
    int                  wr_count = 0;
    int                  bad_addr = 0;

    int checks = 0;
    int errors = 0;

    vec_t  vecs [NVEC];
    string names [NVEC];

    line_clear_engine dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared),
        .cleared_mask  (cleared_mask),
        .ram_addr      (ram_addr),
        .ram_wren      (ram_wren),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata)
    );

    always #5 CLK = ~CLK;

    // Board RAM: one-cycle read latency, bench preload has priority over DUT writes.
    always @(posedge CLK) begin
        if (tb_load) begin
            for (int i = 0; i < 32; i++) mem[i] <= SENT;
            for (int i = 0; i < int'(NR); i++) mem[RB+i] <= tb_board[i];
        end else if (ram_wren) begin
            if (ram_addr >= 11'd32) bad_addr <= bad_addr + 1;
            else mem[ram_addr[4:0]] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr[4:0]];
        if (tb_clr) wr_count <= 0;
        else if (ram_wren) wr_count <= wr_count + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_board(input logic [NR-1:0][31:0] b);
        @(negedge CLK);
        tb_board = b;
        tb_load  = 1'b1;
        tb_clr   = 1'b1;
        @(negedge CLK);
        tb_load  = 1'b0;
        tb_clr   = 1'b0;
    endtask

    // Pulses start, optionally re-pulses it mid-run, and returns the cycle done was seen.
    task automatic start_and_wait(input int extra_start_at, output int cyc);
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 200) begin
            if (cyc == extra_start_at) start = 1'b1;
            @(posedge CLK);
            #1;
            start = 1'b0;
            cyc++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string name, input int extra_start_at);
        int cyc;
        load_board(v.init);
        start_and_wait(extra_start_at, cyc);
        if (cyc >= 200) begin
            errors++;
            $display("FAIL %s timeout: done not seen within %0d cycles", name, cyc);
        end
        checks++;
        check({name, " latency"}, 64'(cyc), 64'(41 + int'(v.lines)));
        @(posedge CLK);
        #1;
        check({name, " busy_after"}, 64'(busy), 64'd0);
        check({name, " done_pulse"}, 64'(done), 64'd0);
        check({name, " lines"}, 64'(lines_cleared), 64'(v.lines));
        check({name, " mask"}, 64'(cleared_mask), 64'(v.mask));
        check({name, " writes"}, 64'(wr_count), 64'(v.writes));
        check({name, " bad_addr"}, 64'(bad_addr), 64'd0);
        for (int i = 0; i < int'(NR); i++)
            check($sformatf("%s row%0d", name, i), 64'(mem[RB+i]), 64'(v.expd[i]));
        check({name, " sent0"}, 64'(mem[0]), 64'(SENT));
        check({name, " sent1"}, 64'(mem[1]), 64'(SENT));
        check({name, " sent22"}, 64'(mem[22]), 64'(SENT));
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < int'(NVEC); i++) vecs[i] = '0;

        names[0] = "empty";
        vecs[0].lines = 5'd0;  vecs[0].mask = 20'h0;     vecs[0].writes = 8'd0;

        names[1] = "one_bottom";
        vecs[1].init[19] = 32'h00055555; vecs[1].init[18] = 32'h00000001;
        vecs[1].expd[19] = 32'h00000001;
        vecs[1].lines = 5'd1;  vecs[1].mask = 20'h80000; vecs[1].writes = 8'd20;

        names[2] = "four_full";
        for (int r = 16; r < 20; r++) vecs[2].init[r] = 32'h000AAAAA;
        vecs[2].init[15] = 32'h000AAAA8;
        vecs[2].expd[19] = 32'h000AAAA8;
        vecs[2].lines = 5'd4;  vecs[2].mask = 20'hF0000; vecs[2].writes = 8'd20;

        names[3] = "cell9_empty";
        vecs[3].init[19] = 32'h00015555; vecs[3].expd[19] = 32'h00015555;
        vecs[3].lines = 5'd0;  vecs[3].mask = 20'h0;     vecs[3].writes = 8'd0;

        names[4] = "interleaved";
        vecs[4].init[19] = 32'h00055555; vecs[4].init[18] = 32'h00000003;
        vecs[4].init[17] = 32'h000FFFFF; vecs[4].init[16] = 32'h0000000C;
        vecs[4].expd[19] = 32'h00000003; vecs[4].expd[18] = 32'h0000000C;
        vecs[4].lines = 5'd2;  vecs[4].mask = 20'hA0000; vecs[4].writes = 8'd20;

        names[5] = "all_full";
        for (int r = 0; r < int'(NR); r++) vecs[5].init[r] = 32'h000FFFFF;
        vecs[5].lines = 5'd20; vecs[5].mask = 20'hFFFFF; vecs[5].writes = 8'd20;

        names[6] = "high_bits";
        vecs[6].init[19] = 32'h00155555; vecs[6].init[18] = 32'hFFF00001;
        vecs[6].init[10] = 32'h7FFAAAAA; vecs[6].init[5]  = 32'h00000100;
        vecs[6].expd[19] = 32'hFFF00001; vecs[6].expd[7]  = 32'h00000100;
        vecs[6].lines = 5'd2;  vecs[6].mask = 20'h80400; vecs[6].writes = 8'd20;

        names[7] = "top_row_full";
        vecs[7].init[0] = 32'h000FFFFF; vecs[7].init[1] = 32'h00000001;
        vecs[7].expd[1] = 32'h00000001;
        vecs[7].lines = 5'd1;  vecs[7].mask = 20'h00001; vecs[7].writes = 8'd1;

        RESET = 1'b1;
        start = 1'b0;
        @(posedge CLK);
        #1;
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst wren", 64'(ram_wren), 64'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        check("rst lines", 64'(lines_cleared), 64'd0);
        check("rst mask", 64'(cleared_mask), 64'd0);
        check("rst addr", 64'(ram_addr), 64'd0);
        check("rst wdata", 64'(ram_wdata), 64'd0);
        check("rst busy_idle", 64'(busy), 64'd0);

        for (int v = 0; v < int'(NVEC); v++) run_vec(vecs[v], names[v], 0);

        // A second start while busy must not restart or extend the run.
        run_vec(vecs[1], "restart_ignored", 5);

        // Reset in the middle of a run, during an EVAL that would write.
        load_board(vecs[2].init);
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        check("mid busy_start", 64'(busy), 64'd1);
        for (int i = 1; i < 10; i++) begin
            @(posedge CLK);
            #1;
        end
        RESET = 1'b1;
        #1;
        check("mid wren_in_reset", 64'(ram_wren), 64'd0);
        check("mid busy_in_reset", 64'(busy), 64'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        check("mid busy_after", 64'(busy), 64'd0);
        check("mid wren_after", 64'(ram_wren), 64'd0);
        check("mid lines_after", 64'(lines_cleared), 64'd0);
        cyc = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge CLK);
            #1;
            if (done || busy) cyc++;
        end
        check("mid stays_idle", 64'(cyc), 64'd0);

        run_vec(vecs[2], "after_reset", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
